// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one 4-bit ALU among NREQ requesters,
// with a one-cycle execute slot and a valid/ready response register.
`default_nettype none

module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int OPW  = 4,
  parameter int DW   = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ-1:0]     req_cin,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [OPW-1:0]      alu_op,
  output logic                alu_cin,
  input  logic [DW-1:0]       alu_y,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic                alu_c,
  input  logic                alu_v,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_y,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  lat_id;
  logic            lat_err;

  logic            any_req;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  ptr_next;
  logic [OPW-1:0]  grant_op;
  logic [DW-1:0]   grant_a;
  logic [DW-1:0]   grant_b;
  logic            grant_cin;
  logic            grant_legal;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (!any_req && req_valid[j]) begin
        any_req   = 1'b1;
        grant_idx = j[IDW-1:0];
      end
    end
  end

  assign ptr_next    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_op    = req_op[grant_idx*OPW +: OPW];
  assign grant_a     = req_a[grant_idx*DW +: DW];
  assign grant_b     = req_b[grant_idx*DW +: DW];
  assign grant_cin   = req_cin[grant_idx];
  assign grant_legal = (grant_op >= OPW'(1)) && (grant_op <= OPW'(9));

  // Accept strobe is suppressed while reset is asserted so no requester sees a false accept.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && any_req) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lat_id    <= '0;
      lat_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= EXEC;
            busy    <= 1'b1;
            ptr     <= ptr_next;
            lat_id  <= grant_idx;
            lat_err <= !grant_legal;
            // ALU drive is loaded here so it is valid for exactly the EXEC cycle.
            if (grant_legal) begin
              alu_op  <= grant_op;
              alu_a   <= grant_a;
              alu_b   <= grant_b;
              alu_cin <= grant_cin;
            end else begin
              alu_op  <= '0;
              alu_a   <= '0;
              alu_b   <= '0;
              alu_cin <= 1'b0;
            end
          end
        end
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          rsp_err   <= lat_err;
          rsp_y     <= lat_err ? '0 : alu_y;
          rsp_flags <= lat_err ? 4'b0000 : {alu_n, alu_z, alu_c, alu_v};
          alu_op    <= '0;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_cin   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, execute slot, response
// handshake, illegal opcodes and reset, against a small behavioural ALU.
`default_nettype none

module tb_alu_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [15:0]     req_op;
  logic [15:0]     req_a;
  logic [15:0]     req_b;
  logic [3:0]      req_cin;
  logic [3:0]      alu_a, alu_b, alu_op;
  logic            alu_cin;
  logic [3:0]      alu_y;
  logic            alu_n, alu_z, alu_c, alu_v;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [3:0]      rsp_y, rsp_flags;
  logic            rsp_err, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NREQ(NREQ), .OPW(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural stand-in for the shared ALU; C on subtract is the borrow.
  logic [4:0] sum;
  always_comb begin
    sum   = 5'd0;
    alu_y = 4'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      4'd1: alu_y = alu_a & alu_b;
      4'd2: alu_y = alu_a | alu_b;
      4'd3: alu_y = alu_a ^ alu_b;
      4'd4: alu_y = ~alu_a;
      4'd5: alu_y = alu_a;
      4'd6: alu_y = alu_b;
      4'd7: begin
        sum   = {1'b0, alu_a} + 5'd1;
        alu_y = sum[3:0];
        alu_c = sum[4];
      end
      4'd8: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_y = sum[3:0];
        alu_c = sum[4];
        alu_v = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
      end
      4'd9: begin
        sum   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_y = sum[3:0];
        alu_c = sum[4];
        alu_v = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
      end
      default: alu_y = 4'd0;
    endcase
    alu_n = alu_y[3];
    alu_z = (alu_y == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic cin);
    req_op[i*4 +: 4] = op;
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_cin[i]       = cin;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_cin = '0; rsp_ready = 1'b0;
    repeat (3) step();

    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_y",     32'(rsp_y),     32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    rst_n = 1'b1;
    step();

    // Single add with carry on requester 2
    set_lane(2, 4'h8, 4'h7, 4'h9, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("add_ready", 32'(req_ready), 32'b0100);
    chk("add_busy_idle", 32'(busy), 32'd0);
    step();
    req_valid = 4'b0000;
    #1;
    chk("add_ready_drop", 32'(req_ready), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_alu_op", 32'(alu_op), 32'h8);
    chk("add_alu_a", 32'(alu_a), 32'h7);
    chk("add_alu_b", 32'(alu_b), 32'h9);
    chk("add_alu_cin", 32'(alu_cin), 32'd1);
    chk("add_no_rsp_yet", 32'(rsp_valid), 32'd0);
    step();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_id", 32'(rsp_id), 32'd2);
    chk("add_rsp_y", 32'(rsp_y), 32'h1);
    chk("add_rsp_flags", 32'(rsp_flags), 32'b0010);
    chk("add_rsp_err", 32'(rsp_err), 32'd0);
    chk("add_alu_op_idle", 32'(alu_op), 32'd0);
    rsp_ready = 1'b1;
    step();
    chk("add_done_valid", 32'(rsp_valid), 32'd0);
    chk("add_done_busy", 32'(busy), 32'd0);

    // Illegal opcode on requester 0; pointer is 3 so the search wraps to 0
    set_lane(0, 4'hC, 4'hF, 4'hF, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("ill_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    #1;
    chk("ill_alu_op", 32'(alu_op), 32'd0);
    chk("ill_alu_a", 32'(alu_a), 32'd0);
    chk("ill_alu_b", 32'(alu_b), 32'd0);
    step();
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_err", 32'(rsp_err), 32'd1);
    chk("ill_rsp_y", 32'(rsp_y), 32'd0);
    chk("ill_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("ill_rsp_id", 32'(rsp_id), 32'd0);
    step();

    // Subtract on requester 1, then hold the response under back-pressure
    rsp_ready = 1'b0;
    set_lane(1, 4'h9, 4'h3, 4'h5, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("sub_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    chk("sub_rsp_y", 32'(rsp_y), 32'hE);
    chk("sub_rsp_flags", 32'(rsp_flags), 32'b1010);
    chk("sub_rsp_id", 32'(rsp_id), 32'd1);
    chk("sub_rsp_err", 32'(rsp_err), 32'd0);
    set_lane(1, 4'h1, 4'hC, 4'hA, 1'b0);
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_y", 32'(rsp_y), 32'hE);
      chk("bp_rsp_flags", 32'(rsp_flags), 32'b1010);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_bypass", 32'(req_ready), 32'd0);
    step();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    chk("and_rsp_id", 32'(rsp_id), 32'd1);
    chk("and_rsp_y", 32'(rsp_y), 32'h8);
    chk("and_rsp_flags", 32'(rsp_flags), 32'b1000);
    step();

    // Round-robin from reset with every requester asserting
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 4'h8, 4'h1, 4'h2, 1'b0);
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 13; i++) begin
      logic [3:0] exp_rdy;
      if (i > 0) step();
      exp_rdy = (i % 3 == 0) ? 4'(1 << ((i / 3) % 4)) : 4'b0000;
      chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
    end

    // Reset asserted during EXEC drops the operation and the pointer
    req_valid = 4'b0000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_lane(1, 4'h8, 4'h1, 4'h1, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("mid_busy_exec", 32'(busy), 32'd1);
    step();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_idle", 32'(busy), 32'd0);
    end
    req_valid = 4'b0011;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
